bcd_time_gen: RTL
=================

# bcd_time_gen

Six-digit BCD time-of-day generator (HH:MM:SS) that produces the 24-bit packed digit word consumed by the seg7 scan driver. It replaces the free-running test-pattern data generator upstream of the display. The block runs on the 50 MHz system clock and derives its one-second tick with an internal prescaler, so it needs no divided clock. It supports run/pause and a validated parallel load for setting the time.

## Interface
- TICK_DIV, 50000000: system clock cycles per second. Must be ≥ 2. Benches use a small value.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable. High: time advances. Low: prescaler and time are frozen.
- load  input  1  single-cycle request to load load_data.
- load_data  input  24  packed BCD time to load, same layout as data_out.
- data_out  output  24  packed BCD time to seg7:
  - [23:20] hours tens, [19:16] hours units
  - [15:12] minutes tens, [11:8] minutes units
  - [7:4] seconds tens, [3:0] seconds units
- sec_pulse  output  1  one-cycle pulse on each one-second increment.
- day_wrap  output  1  one-cycle pulse when time wraps from 23:59:59 to 00:00:00.
- load_err  output  1  one-cycle pulse when a load request is rejected.

## Operation
- Reset: on a clock edge with rst=1, the following all go to 0 on that edge:
  - data_out = 24'h000000
  - prescaler count
  - sec_pulse, day_wrap, load_err
- rst has priority over every other input.
- Prescaler:
  - Width is ceil(log2(TICK_DIV)).
  - Counts 0..TICK_DIV-1 while en=1 and then wraps to 0.
  - A tick occurs on the edge where count == TICK_DIV-1 and en=1.
- Increment on tick, using BCD arithmetic only (no binary intermediate):
  - Seconds units 9→0 carries into seconds tens.
  - Seconds tens 5→0 carries into minutes units.
  - Minutes follow the same pattern: units 0-9, tens 0-5.
  - Hours roll over at 23→00. Units go 0-9 while tens < 2, and 0-3 when tens = 2.
- Load validity: a load is valid when all of the following hold:
  - every nibble is ≤ 9
  - seconds tens ≤ 5 and minutes tens ≤ 5
  - hours tens ≤ 2
  - if hours tens = 2, hours units ≤ 3
- Valid load:
  - data_out takes load_data on the next edge.
  - Prescaler count resets to 0.
  - No sec_pulse is produced for that edge, even if a tick would have occurred.
- Invalid load:
  - data_out and prescaler behave as if load were 0, so a coincident tick still increments.
  - load_err pulses.
- Loads are accepted regardless of en.
- Priority: rst > valid load > tick > hold.
- en=0 holds the prescaler count. Dropping en mid-second and raising it later resumes the count; it does not restart it.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Tick edge:
  - data_out shows the incremented value in the cycle after the edge where count == TICK_DIV-1.
  - sec_pulse is high in that same cycle.
  - Period: exactly TICK_DIV cycles between successive sec_pulse while en stays high.
- day_wrap is high in the same cycle as the sec_pulse that shows 00:00:00.
- Load:
  - 1-cycle latency: load sampled at edge N, new value visible after edge N.
  - After a valid load, the first sec_pulse arrives TICK_DIV cycles later, provided en is held high.
  - load_err is visible one cycle after the rejected load.
- Back-to-back loads on consecutive cycles are each evaluated independently; the last valid one wins.
- Mid-operation reset: outputs are cleared on the reset edge and no pending pulse survives it.
- After rst deasserts with en=1, the first tick occurs TICK_DIV cycles later.

## Test plan
All scenarios use TICK_DIV=4.
- Reset then run: rst 2 cycles, en=1 for 40 cycles → data_out 000000 → 000001 … 000010. sec_pulse every 4 cycles, 10 pulses total.
- Carry chain: load 0x235958, en=1 → after 2 ticks data_out = 0x000000. day_wrap pulses once, coincident with the second sec_pulse.
- Minute/hour carry: load 0x095959 → next tick 0x100000. Load 0x195959 → next tick 0x200000.
- Invalid loads:
  - 0x240000, 0x006000, 0x0000A0 each leave data_out unchanged and pulse load_err.
  - 0x235959 is accepted without load_err.
- Pause and resume: en=0 for 10 cycles mid-second → data_out and sec_pulse frozen. On resume, the tick occurs after the remaining prescaler cycles only.
- Collision and reset:
  - Valid load on the tick edge → load value shown, no sec_pulse.
  - rst asserted mid-count with en=1 → data_out = 0 next cycle; first sec_pulse 4 cycles after rst drops.

Source files
------------

// File: rtl/bcd_time_gen.sv
// -----------------------------------------------------------------------------
// bcd_time_gen
// Six-digit BCD time-of-day generator (HH:MM:SS) that feeds the seg7 scan
// driver. A prescaler turns the system clock into a one-second tick. The time
// can be paused with en and set with a range-checked parallel load.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   en         run enable; low freezes both the prescaler and the time
//   load       single-cycle request to load load_data
//   load_data  packed BCD time, same layout as data_out
//   data_out   {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u}, one nibble each
//   sec_pulse  one-cycle pulse on each one-second increment
//   day_wrap   one-cycle pulse when 23:59:59 rolls over to 00:00:00
//   load_err   one-cycle pulse when a load request is rejected
// -----------------------------------------------------------------------------
module bcd_time_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [23:0] load_data,
    output logic [23:0] data_out,
    output logic        sec_pulse,
    output logic        day_wrap,
    output logic        load_err
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q,  cnt_d;
    logic [23:0]   time_q, time_d;
    logic          sec_q,  sec_d;
    logic          wrap_q, wrap_d;
    logic          err_q,  err_d;

    logic tick;
    logic load_ok;

    // Range check of a packed HH:MM:SS word.
    function automatic logic bcd_valid(input logic [23:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (t[7:4]   > 4'd5) ok = 1'b0;
        if (t[15:12] > 4'd5) ok = 1'b0;
        if (t[23:20] > 4'd2) ok = 1'b0;
        if (t[23:20] == 4'd2 && t[19:16] > 4'd3) ok = 1'b0;
        return ok;
    endfunction

    // Digit-by-digit increment: each digit only moves when every lower digit
    // sits at its own maximum, so the carry ripples purely in BCD.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [3:0] s0, s1, m0, m1, h0, h1;
        {h1, h0, m1, m0, s1, s0} = t;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    if (m1 != 4'd5) begin
                        m1 = m1 + 4'd1;
                    end else begin
                        m1 = 4'd0;
                        // Hours units top out at 3 once tens reaches 2.
                        if (h1 == 4'd2 && h0 == 4'd3) begin
                            h1 = 4'd0;
                            h0 = 4'd0;
                        end else if (h0 == 4'd9) begin
                            h0 = 4'd0;
                            h1 = h1 + 4'd1;
                        end else begin
                            h0 = h0 + 4'd1;
                        end
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    assign tick    = en && (cnt_q == CNT_LAST);
    assign load_ok = load && bcd_valid(load_data);

    always_comb begin
        cnt_d  = cnt_q;
        time_d = time_q;
        sec_d  = 1'b0;
        wrap_d = 1'b0;
        err_d  = 1'b0;

        if (tick) begin
            cnt_d  = '0;
            time_d = bcd_inc(time_q);
            sec_d  = 1'b1;
            wrap_d = (time_q == 24'h235959);
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end

        // An accepted load overrides a coincident tick and restarts the second.
        // A rejected one leaves the tick/hold path untouched.
        if (load_ok) begin
            time_d = load_data;
            cnt_d  = '0;
            sec_d  = 1'b0;
            wrap_d = 1'b0;
        end else if (load) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            time_q <= '0;
            sec_q  <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            time_q <= time_d;
            sec_q  <= sec_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign data_out  = time_q;
    assign sec_pulse = sec_q;
    assign day_wrap  = wrap_q;
    assign load_err  = err_q;

endmodule
